// File: rtl/retospect_neuron.sv
// retospect_neuron -- parametrised spiking neuron cell for the FPNA fabric.
//
// Sums the weights of all active dendrites in one cycle. Applies leak
// selected from the clockbus. Saturates the membrane potential, and fires
// when a programmable threshold is reached. After each spike it holds off
// for a programmable refractory period.
//
// Configuration sits in a serial chain: w[0] .. w[N_DEND-1], thr, sel, refr.
// w[0] is nearest bs_in and refr is nearest bs_out. The chain is one shift
// register with bs_in entering at the MSB. bs_out is the LSB.
//
// Optional feature macro: RETOSPECT_NEURON_INHIBIT_EN
//   defined   : weights are two's-complement signed; next potential is
//               clamped to [0, 2^POT_BITS-1].
//   undefined : weights are unsigned; only the upper clamp applies.
//
// Ports:
//   clk        fabric clock, rising edge
//   reset      synchronous active-high full reset (clears configuration too)
//   reset_nn   network reset: pot=1, runtime state cleared, config kept
//   config_en  shift the configuration chain by one bit
//   bs_in      bitstream serial input
//   bs_out     bitstream serial output (LSB of refr field)
//   clockbus   decay strobes from the clockbox
//   dendrite   spike inputs
//   axon       registered one-cycle spike output
module retospect_neuron #(
  parameter int N_DEND    = 4,
  parameter int W_BITS    = 3,
  parameter int POT_BITS  = 4,
  parameter int N_CLK     = 8,
  parameter int REFR_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_nn,
  input  logic              config_en,
  input  logic              bs_in,
  output logic              bs_out,
  input  logic [N_CLK-1:0]  clockbus,
  input  logic [N_DEND-1:0] dendrite,
  output logic              axon
);
  localparam int SEL_BITS = (N_CLK > 1) ? $clog2(N_CLK) : 1;
  localparam int L        = N_DEND*W_BITS + POT_BITS + SEL_BITS + REFR_BITS;
  localparam int OFS_SEL  = REFR_BITS;
  localparam int OFS_THR  = OFS_SEL + SEL_BITS;
  localparam int OFS_W    = OFS_THR + POT_BITS;
  // Wide enough for pot plus N_DEND (<=8) full-scale weights, with a sign bit.
  localparam int ACC_W    = POT_BITS + W_BITS + 5;
  localparam logic [POT_BITS-1:0]     POT_MAX = '1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2**POT_BITS) - 1);

  logic [L-1:0]          chain;
  logic [POT_BITS-1:0]   pot;
  logic [REFR_BITS-1:0]  rcnt;
  logic [POT_BITS-1:0]   thr;
  logic [SEL_BITS-1:0]   sel;
  logic [REFR_BITS-1:0]  refr;
  logic [POT_BITS-1:0]   leaked;
  logic [POT_BITS-1:0]   next_pot;
  logic [W_BITS-1:0]     wi;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc;
  logic                  leak_en;
  logic                  fire;

  assign refr   = chain[0 +: REFR_BITS];
  assign sel    = chain[OFS_SEL +: SEL_BITS];
  assign thr    = chain[OFS_THR +: POT_BITS];
  assign bs_out = chain[0];

  always_comb begin
    // Out-of-range sel values fall back to clockbus[0].
    leak_en = clockbus[0];
    for (int k = 1; k < N_CLK; k++)
      if (sel == SEL_BITS'(k)) leak_en = clockbus[k];
    leaked = leak_en ? (pot >> 1) : pot;

    sum = '0;
    wi  = '0;
    for (int i = 0; i < N_DEND; i++) begin
      // w[0] is the highest field in the chain.
      wi = chain[OFS_W + (N_DEND-1-i)*W_BITS +: W_BITS];
      if (dendrite[i]) begin
`ifdef RETOSPECT_NEURON_INHIBIT_EN
        sum = sum + {{(ACC_W-W_BITS){wi[W_BITS-1]}}, wi};
`else
        sum = sum + {{(ACC_W-W_BITS){1'b0}}, wi};
`endif
      end
    end
    acc = {{(ACC_W-POT_BITS){1'b0}}, leaked} + sum;

`ifdef RETOSPECT_NEURON_INHIBIT_EN
    if (acc[ACC_W-1])        next_pot = '0;
    else if (acc > ACC_MAX)  next_pot = POT_MAX;
    else                     next_pot = acc[POT_BITS-1:0];
`else
    if (acc > ACC_MAX)       next_pot = POT_MAX;
    else                     next_pot = acc[POT_BITS-1:0];
`endif

    fire = (thr != '0) && (next_pot >= thr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      pot   <= '0;
      rcnt  <= '0;
      axon  <= 1'b0;
    end else if (reset_nn) begin
      pot   <= POT_BITS'(1);
      rcnt  <= '0;
      axon  <= 1'b0;
    end else if (config_en) begin
      // pot and rcnt freeze while the chain shifts.
      chain <= {bs_in, chain[L-1:1]};
      axon  <= 1'b0;
    end else if (rcnt != '0) begin
      pot   <= '0;
      rcnt  <= rcnt - 1'b1;
      axon  <= 1'b0;
    end else if (fire) begin
      pot   <= '0;
      rcnt  <= refr;
      axon  <= 1'b1;
    end else begin
      pot   <= next_pot;
      axon  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_retospect_neuron.sv
// Self-checking bench for retospect_neuron: directed scenarios plus a
// randomized run against a behavioural model kept in the bench.
module tb_retospect_neuron;
  localparam int N_DEND    = 4;
  localparam int W_BITS    = 3;
  localparam int POT_BITS  = 4;
  localparam int N_CLK     = 8;
  localparam int REFR_BITS = 2;
  localparam int SEL_BITS  = $clog2(N_CLK);
  localparam int L         = N_DEND*W_BITS + POT_BITS + SEL_BITS + REFR_BITS;
  localparam int PMAX      = (1 << POT_BITS) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0, reset_nn = 1'b0, config_en = 1'b0, bs_in = 1'b0;
  logic              bs_out, axon;
  logic [N_CLK-1:0]  clockbus = '0;
  logic [N_DEND-1:0] dendrite = '0;

  int errors = 0;
  int checks = 0;

  // model state
  bit mq[$];          // mq[0] is the bit at bs_out
  int m_pot, m_rcnt;
  bit m_axon;
  int cw[N_DEND];     // weights to load

  retospect_neuron #(.N_DEND(N_DEND), .W_BITS(W_BITS), .POT_BITS(POT_BITS),
                     .N_CLK(N_CLK), .REFR_BITS(REFR_BITS)) dut (
    .clk(clk), .reset(reset), .reset_nn(reset_nn), .config_en(config_en),
    .bs_in(bs_in), .bs_out(bs_out), .clockbus(clockbus),
    .dendrite(dendrite), .axon(axon));

  always #5 clk = ~clk;

  function automatic int fld(int ofs, int wd);
    int r = 0;
    for (int b = 0; b < wd; b++) if (mq[ofs+b]) r += (1 << b);
    return r;
  endfunction

  task automatic model_update();
    int p, refr_v, sel_v, thr_v, wv, s, leaked, nx;
    bit lk;
    if (reset) begin
      for (int i = 0; i < L; i++) mq[i] = 1'b0;
      m_pot = 0; m_rcnt = 0; m_axon = 0;
    end else if (reset_nn) begin
      m_pot = 1; m_rcnt = 0; m_axon = 0;
    end else if (config_en) begin
      void'(mq.pop_front());
      mq.push_back(bs_in);
      m_axon = 0;
    end else if (m_rcnt > 0) begin
      m_rcnt--; m_pot = 0; m_axon = 0;
    end else begin
      p = 0;
      refr_v = fld(p, REFR_BITS); p += REFR_BITS;
      sel_v  = fld(p, SEL_BITS);  p += SEL_BITS;
      thr_v  = fld(p, POT_BITS);  p += POT_BITS;
      s = 0;
      for (int i = N_DEND-1; i >= 0; i--) begin
        wv = fld(p, W_BITS); p += W_BITS;
`ifdef RETOSPECT_NEURON_INHIBIT_EN
        if (wv >= (1 << (W_BITS-1))) wv -= (1 << W_BITS);
`endif
        if (dendrite[i]) s += wv;
      end
      lk = (sel_v < N_CLK) ? clockbus[sel_v] : clockbus[0];
      leaked = lk ? m_pot / 2 : m_pot;
      nx = leaked + s;
      if (nx < 0) nx = 0;
      if (nx > PMAX) nx = PMAX;
      if (thr_v != 0 && nx >= thr_v) begin
        m_axon = 1; m_pot = 0; m_rcnt = refr_v;
      end else begin
        m_axon = 0; m_pot = nx;
      end
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int thr, input int sel, input int refr);
    logic [L-1:0] v;
    int pos;
    v = '0; pos = 0;
    for (int b = 0; b < REFR_BITS; b++) v[pos++] = 1'((refr >> b) & 1);
    for (int b = 0; b < SEL_BITS; b++)  v[pos++] = 1'((sel >> b) & 1);
    for (int b = 0; b < POT_BITS; b++)  v[pos++] = 1'((thr >> b) & 1);
    for (int i = N_DEND-1; i >= 0; i--)
      for (int b = 0; b < W_BITS; b++)  v[pos++] = 1'((cw[i] >> b) & 1);
    for (int b = 0; b < L; b++) begin
      config_en = 1'b1; bs_in = v[b]; step();
    end
    config_en = 1'b0; bs_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dendrite = '1; clockbus = '1; step(); reset = 1'b0;
    dendrite = '0; clockbus = '0;
    checks++; if (axon !== 1'b0) begin errors++; $display("FAIL reset_axon: got %b want 0", axon); end
    checks++; if (bs_out !== 1'b0) begin errors++; $display("FAIL reset_bs_out: got %b want 0", bs_out); end
    checks++; if (dut.pot !== 4'd0) begin errors++; $display("FAIL reset_pot: got %0d want 0", dut.pot); end
    checks++; if (dut.rcnt !== 2'd0) begin errors++; $display("FAIL reset_rcnt: got %0d want 0", dut.rcnt); end
  endtask

  task automatic test_integrate_fire();
    bit want;
    do_reset();
    cw = '{3, 0, 0, 0};
    dendrite = 4'b0001; clockbus = '0;
    load_cfg(6, 0, 2);
    for (int e = 1; e <= 12; e++) begin
      step();
      want = (e == 2 || e == 6 || e == 10);
      checks++;
      if (axon !== want) begin errors++; $display("FAIL fire_axon_edge%0d: got %b want %b", e, axon, want); end
      if (e == 1) begin
        checks++; if (dut.pot !== 4'd3) begin errors++; $display("FAIL fire_pot_edge1: got %0d want 3", dut.pot); end
      end
    end
    dendrite = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    cw = '{1, 2, 3, 4};
    load_cfg(15, 0, 0);
    dendrite = 4'b1111; step(); dendrite = '0;
    checks++; if (dut.pot !== 4'd10) begin errors++; $display("FAIL simul_pot1: got %0d want 10", dut.pot); end
    checks++; if (axon !== 1'b0) begin errors++; $display("FAIL simul_axon1: got %b want 0", axon); end
    dendrite = 4'b1111; step(); dendrite = '0;
    checks++; if (axon !== 1'b1) begin errors++; $display("FAIL simul_axon2: got %b want 1", axon); end
    checks++; if (dut.pot !== 4'd0) begin errors++; $display("FAIL simul_pot2: got %0d want 0", dut.pot); end
  endtask

  task automatic test_leak();
    do_reset();
    cw = '{0, 0, 0, 0};
    load_cfg(1, 1, 0);
    clockbus = 8'b0000_0010;
    reset_nn = 1'b1; step(); reset_nn = 1'b0;
    checks++; if (dut.pot !== 4'd1) begin errors++; $display("FAIL leak_pot_nn: got %0d want 1", dut.pot); end
    step();
    checks++; if (dut.pot !== 4'd0) begin errors++; $display("FAIL leak_pot: got %0d want 0", dut.pot); end
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (axon !== 1'b0) begin errors++; $display("FAIL leak_axon_c%0d: got %b want 0", c, axon); end
    end
    clockbus = '0;
  endtask

  task automatic test_chain();
    logic [20:0] pat;
    bit strm[42];
    bit want;
    do_reset();
    pat = 21'h15A3C;
    for (int j = 0; j < 42; j++) strm[j] = (j < 21) ? pat[j] : 1'b0;
    for (int k = 1; k <= 42; k++) begin
      config_en = 1'b1; bs_in = strm[k-1]; step();
      want = (k >= L) ? strm[k-L] : 1'b0;
      checks++;
      if (bs_out !== want) begin errors++; $display("FAIL chain_shift%0d: got %b want %b", k, bs_out, want); end
      if (k == 30) begin
        config_en = 1'b0;
        for (int g = 0; g < 3; g++) begin
          step();
          checks++;
          if (bs_out !== want) begin errors++; $display("FAIL chain_gap%0d: got %b want %b", g, bs_out, want); end
        end
      end
    end
    config_en = 1'b0; bs_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cw = '{6, 0, 0, 0};
    load_cfg(6, 0, 3);
    dendrite = 4'b0001;
    step();
    checks++; if (axon !== 1'b1 || dut.rcnt !== 2'd3) begin errors++; $display("FAIL rmid_fire: axon %b rcnt %0d want 1/3", axon, dut.rcnt); end
    reset_nn = 1'b1; step(); reset_nn = 1'b0;
    checks++; if (dut.rcnt !== 2'd0 || dut.pot !== 4'd1 || axon !== 1'b0) begin
      errors++; $display("FAIL rmid_nn: rcnt %0d pot %0d axon %b want 0/1/0", dut.rcnt, dut.pot, axon); end
    step();
    checks++; if (axon !== 1'b1) begin errors++; $display("FAIL rmid_resume: got %b want 1", axon); end
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (axon !== 1'b0 || dut.pot !== 4'd0) begin
        errors++; $display("FAIL rmid_after_reset_c%0d: axon %b pot %0d want 0/0", c, axon, dut.pot); end
    end
    dendrite = '0;
  endtask

  task automatic test_cfg_freeze();
    do_reset();
    cw = '{6, 0, 0, 0};
    load_cfg(6, 0, 3);
    dendrite = 4'b0001;
    step(); step();
    checks++; if (dut.rcnt !== 2'd2) begin errors++; $display("FAIL freeze_pre: got %0d want 2", dut.rcnt); end
    config_en = 1'b1; bs_in = 1'b0; step(); step(); config_en = 1'b0;
    checks++; if (dut.rcnt !== 2'd2 || axon !== 1'b0) begin
      errors++; $display("FAIL freeze_hold: rcnt %0d axon %b want 2/0", dut.rcnt, axon); end
    dendrite = '0;
  endtask

`ifdef RETOSPECT_NEURON_INHIBIT_EN
  task automatic test_inhibit();
    do_reset();
    cw = '{7, 3, 0, 0};
    load_cfg(15, 0, 0);
    dendrite = 4'b0010; step();
    checks++; if (dut.pot !== 4'd3) begin errors++; $display("FAIL inh_excite: got %0d want 3", dut.pot); end
    dendrite = 4'b0001; step();
    checks++; if (dut.pot !== 4'd2) begin errors++; $display("FAIL inh_inhibit: got %0d want 2", dut.pot); end
    dendrite = 4'b0000; reset_nn = 1'b1; step(); reset_nn = 1'b0;
    dendrite = 4'b0001; step(); step();
    checks++; if (dut.pot !== 4'd0) begin errors++; $display("FAIL inh_floor: got %0d want 0", dut.pot); end
    dendrite = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N_DEND; i++) cw[i] = $urandom_range(0, (1 << W_BITS) - 1);
      load_cfg($urandom_range(0, PMAX), $urandom_range(0, N_CLK-1), $urandom_range(0, 3));
      for (int c = 0; c < 150; c++) begin
        dendrite  = N_DEND'($urandom);
        clockbus  = N_CLK'($urandom);
        reset_nn  = ($urandom_range(0, 15) == 0);
        config_en = ($urandom_range(0, 19) == 0);
        bs_in     = 1'($urandom);
        reset     = ($urandom_range(0, 299) == 0);
        step();
        checks++; if (axon !== m_axon) begin errors++; $display("FAIL rnd_axon r%0d c%0d: got %b want %b", r, c, axon, m_axon); end
        checks++; if (dut.pot !== 4'(m_pot)) begin errors++; $display("FAIL rnd_pot r%0d c%0d: got %0d want %0d", r, c, dut.pot, m_pot); end
        checks++; if (dut.rcnt !== 2'(m_rcnt)) begin errors++; $display("FAIL rnd_rcnt r%0d c%0d: got %0d want %0d", r, c, dut.rcnt, m_rcnt); end
        checks++; if (bs_out !== mq[0]) begin errors++; $display("FAIL rnd_bs_out r%0d c%0d: got %b want %b", r, c, bs_out, mq[0]); end
      end
      reset = 1'b0; reset_nn = 1'b0; config_en = 1'b0;
    end
    dendrite = '0; clockbus = '0;
  endtask

  initial begin
    for (int i = 0; i < L; i++) mq.push_back(1'b0);
    m_pot = 0; m_rcnt = 0; m_axon = 0;
    #1;
    test_reset();
    test_integrate_fire();
    test_simultaneous();
    test_leak();
    test_chain();
    test_reset_mid();
    test_cfg_freeze();
`ifdef RETOSPECT_NEURON_INHIBIT_EN
    test_inhibit();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
